// File: rtl/nv_nvdla_cvif_read_eg_pkg.sv
// Shared sizing for the CVIF read egress response arbiter and its round-robin picker.
package nv_nvdla_cvif_read_eg_pkg;

    localparam int NUM_REQ = 4;
    localparam int PD_W    = 514;
    localparam int WT_W    = 4;
    localparam int SRC_W   = 2;

endpackage

// File: rtl/nv_nvdla_cvif_read_eg_rr_pick.sv
// Rotating-priority search: the first valid requester at or after ptr wins,
// with the search wrapping from the highest index back to 0.
module nv_nvdla_cvif_read_eg_rr_pick
    import nv_nvdla_cvif_read_eg_pkg::*;
#(
    parameter int N  = NUM_REQ,
    parameter int IW = SRC_W
) (
    input  logic [N-1:0]  req_vld_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;

    // Walk candidates ptr, ptr+1, ... (mod N); the first valid one is granted.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum_s >= (IW+1)'(N)) begin
                sum_s = sum_s - (IW+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IW-1:0];
            if (!any_o && req_vld_i[cand_s]) begin
                any_o           = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_cvif_read_eg_rsp_arb.sv
// Weighted round-robin arbiter merging NUM_REQ response streams into one
// registered egress port; each requester may hold the port for a burst of eff_w beats.
module nv_nvdla_cvif_read_eg_rsp_arb #(
    parameter int NUM_REQ = nv_nvdla_cvif_read_eg_pkg::NUM_REQ,
    parameter int PD_W    = nv_nvdla_cvif_read_eg_pkg::PD_W,
    parameter int WT_W    = nv_nvdla_cvif_read_eg_pkg::WT_W
) (
    input  logic                                   nvdla_core_clk,
    input  logic                                   nvdla_core_rst,
    input  logic [NUM_REQ*WT_W-1:0]                cfg_weight,
    input  logic [NUM_REQ-1:0]                     req_vld,
    input  logic [NUM_REQ*PD_W-1:0]                req_pd,
    output logic [NUM_REQ-1:0]                     req_rdy,
    output logic                                   out_vld,
    output logic [PD_W-1:0]                        out_pd,
    output logic [nv_nvdla_cvif_read_eg_pkg::SRC_W-1:0] out_src,
    input  logic                                   out_rdy
);

    import nv_nvdla_cvif_read_eg_pkg::*;

    logic                 ld_s;
    logic                 any_s;
    logic                 do_grant_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [SRC_W-1:0]     gidx_s;
    logic [WT_W-1:0]      w_raw_s;
    logic [WT_W-1:0]      w_eff_s;
    logic [WT_W:0]        c_next_s;

    logic                 out_vld_q, out_vld_d;
    logic [PD_W-1:0]      out_pd_q,  out_pd_d;
    logic [SRC_W-1:0]     out_src_q, out_src_d;
    logic [SRC_W-1:0]     ptr_q,     ptr_d;
    logic [WT_W-1:0]      cnt_q,     cnt_d;

    assign ld_s = out_rdy || !out_vld_q;

    nv_nvdla_cvif_read_eg_rr_pick #(
        .N  (NUM_REQ),
        .IW (SRC_W)
    ) u_pick (
        .req_vld_i (req_vld),
        .ptr_i     (ptr_q),
        .grant_o   (grant_s),
        .idx_o     (gidx_s),
        .any_o     (any_s)
    );

    // Reset must hold every requester off, since nothing it hands over would be kept.
    assign do_grant_s = ld_s && any_s && !nvdla_core_rst;
    assign req_rdy    = do_grant_s ? grant_s : {NUM_REQ{1'b0}};

    assign w_raw_s  = cfg_weight[gidx_s*WT_W +: WT_W];
    assign w_eff_s  = (w_raw_s == {WT_W{1'b0}}) ? WT_W'(1) : w_raw_s;
    // A burst only continues when the winner is the requester the pointer is parked on.
    assign c_next_s = ((gidx_s == ptr_q) ? {1'b0, cnt_q} : {(WT_W+1){1'b0}}) + (WT_W+1)'(1);

    // Next-state for the output stage and the burst pointer/counter.
    always_comb begin
        out_vld_d = out_vld_q;
        out_pd_d  = out_pd_q;
        out_src_d = out_src_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (ld_s) begin
            if (any_s) begin
                out_vld_d = 1'b1;
                out_pd_d  = req_pd[gidx_s*PD_W +: PD_W];
                out_src_d = gidx_s;
                if (c_next_s < {1'b0, w_eff_s}) begin
                    ptr_d = gidx_s;
                    cnt_d = c_next_s[WT_W-1:0];
                end else begin
                    ptr_d = (gidx_s == SRC_W'(NUM_REQ-1)) ? SRC_W'(0) : gidx_s + SRC_W'(1);
                    cnt_d = {WT_W{1'b0}};
                end
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // State registers with synchronous reset; a beat held at reset is dropped.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            out_vld_q <= 1'b0;
            out_pd_q  <= {PD_W{1'b0}};
            out_src_q <= {SRC_W{1'b0}};
            ptr_q     <= {SRC_W{1'b0}};
            cnt_q     <= {WT_W{1'b0}};
        end else begin
            out_vld_q <= out_vld_d;
            out_pd_q  <= out_pd_d;
            out_src_q <= out_src_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_vld = out_vld_q;
    assign out_pd  = out_pd_q;
    assign out_src = out_src_q;

endmodule

// File: tb/tb_nv_nvdla_cvif_read_eg_rsp_arb.sv
// Directed bench for the egress response arbiter: grant order, stalls, reset,
// plus a randomized stretch with a per-source payload scoreboard.
module tb_nv_nvdla_cvif_read_eg_rsp_arb;

    import nv_nvdla_cvif_read_eg_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ*WT_W-1:0]   cfg_weight;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*PD_W-1:0]   req_pd;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      out_vld;
    logic [PD_W-1:0]           out_pd;
    logic [SRC_W-1:0]          out_src;
    logic                      out_rdy;

    logic [15:0]               tx_seq [NUM_REQ];
    logic [15:0]               rx_seq [NUM_REQ];
    int                        wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]        last_acc;
    logic [PD_W-1:0]           saved_pd;
    int                        n_tests = 0;
    int                        n_fail  = 0;

    always #5 clk = ~clk;

    nv_nvdla_cvif_read_eg_rsp_arb dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_weight     (cfg_weight),
        .req_vld        (req_vld),
        .req_pd         (req_pd),
        .req_rdy        (req_rdy),
        .out_vld        (out_vld),
        .out_pd         (out_pd),
        .out_src        (out_src),
        .out_rdy        (out_rdy)
    );

    function automatic logic [PD_W-1:0] pd_of(input int src, input logic [15:0] seq);
        logic [PD_W-1:0] v;
        v = '0;
        v[15:0]          = seq;
        v[23:16]         = 8'(src);
        v[256 +: 8]      = 8'(src * 37 + 5);
        v[PD_W-1 -: 16]  = ~seq;
        return v;
    endfunction

    // Each requester presents the beat numbered by its own sequence counter.
    always_comb begin
        req_pd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pd[i*PD_W +: PD_W] = pd_of(i, tx_seq[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pd(input string tag, input logic [PD_W-1:0] obs, input logic [PD_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs[31:0], exp[31:0]);
        end
    endtask

    function automatic int sum_eff_w();
        int s;
        logic [WT_W-1:0] w;
        s = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w = cfg_weight[i*WT_W +: WT_W];
            s += (w == 4'd0) ? 1 : int'(w);
        end
        return s;
    endfunction

    // One clock: handshake checks before the edge, scoreboard and fairness after it.
    task automatic cycle();
        logic [NUM_REQ-1:0] acc;
        logic               cons;
        logic [PD_W-1:0]    cpd;
        logic [SRC_W-1:0]   csrc;
        int                 sw;
        #3;
        chk("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'd1);
        chk("rdy_subset_vld", 32'(req_rdy & ~req_vld), 32'd0);
        acc  = req_rdy & req_vld;
        cons = out_vld && out_rdy && !rst;
        cpd  = out_pd;
        csrc = out_src;
        @(posedge clk);
        #1;
        last_acc = acc;
        sw = sum_eff_w();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) tx_seq[i] = tx_seq[i] + 16'd1;
            if (req_vld[i] && !acc[i] && acc != 4'b0000) wait_cnt[i]++;
            else if (!req_vld[i] || acc[i]) wait_cnt[i] = 0;
            chk("no_starve", 32'(wait_cnt[i] <= sw), 32'd1);
        end
        if (cons) begin
            chk_pd("sb_pd", cpd, pd_of(int'(csrc), rx_seq[csrc]));
            rx_seq[csrc] = rx_seq[csrc] + 16'd1;
        end
    endtask

    task automatic drain();
        req_vld = 4'b0000;
        out_rdy = 1'b1;
        cycle();
        chk("drain_vld", 32'(out_vld), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    endtask

    // Hold all requesters valid and check the granted sequence beat by beat.
    task automatic run_seq(input string tag, input int n, input logic [31:0] exp_src [16]);
        for (int k = 0; k < n; k++) begin
            #1;
            chk({tag, "_rdy"}, 32'(req_rdy), 32'(4'b0001 << exp_src[k]));
            cycle();
            chk({tag, "_vld"}, 32'(out_vld), 32'd1);
            chk({tag, "_src"}, 32'(out_src), exp_src[k]);
        end
    endtask

    initial begin
        logic [31:0] seq_a [16];
        logic [31:0] seq_b [16];
        logic [31:0] seq_c [16];
        seq_a = '{0,1,2,3,0,1,0,0,0,0,0,0,0,0,0,0};
        seq_b = '{0,0,1,2,2,2,3,0,0,1,0,0,0,0,0,0};
        seq_c = '{0,1,2,0,0,0,0,0,0,0,0,0,0,0,0,0};
        for (int i = 0; i < NUM_REQ; i++) begin
            tx_seq[i] = 16'd0;
            rx_seq[i] = 16'd0;
            wait_cnt[i] = 0;
        end
        last_acc   = 4'b0000;
        rst        = 1'b1;
        cfg_weight = 16'h1111;
        req_vld    = 4'b1111;
        out_rdy    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'd0);
        cycle();
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk_pd("rst_pd", out_pd, '0);
        rst = 1'b0;

        // Equal weights: plain rotation, first beat one cycle after request.
        run_seq("rr1", 6, seq_a);

        // Weighted bursts; weight 0 behaves as 1.
        drain();
        do_reset();
        cfg_weight = {4'd0, 4'd3, 4'd1, 4'd2};
        req_vld    = 4'b1111;
        run_seq("wrr", 10, seq_b);

        // Stall: pointer is parked at 2 after requester 1's single-beat burst.
        out_rdy  = 1'b0;
        saved_pd = out_pd;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rdy", 32'(req_rdy), 32'd0);
            cycle();
            chk("stall_vld", 32'(out_vld), 32'd1);
            chk("stall_src", 32'(out_src), 32'd1);
            chk_pd("stall_pd", out_pd, saved_pd);
        end
        out_rdy = 1'b1;
        #1;
        chk("unstall_rdy", 32'(req_rdy), 32'd4);
        cycle();
        chk("unstall_src", 32'(out_src), 32'd2);

        // Sparse requests: skip to 2, then 3, then wrap to 0.
        drain();
        do_reset();
        cfg_weight = 16'h1111;
        req_vld    = 4'b0100;
        #1;
        chk("sparse_rdy2", 32'(req_rdy), 32'd4);
        cycle();
        chk("sparse_src2", 32'(out_src), 32'd2);
        req_vld = 4'b1001;
        #1;
        chk("sparse_rdy3", 32'(req_rdy), 32'd8);
        cycle();
        chk("sparse_src3", 32'(out_src), 32'd3);
        #1;
        chk("sparse_rdy0", 32'(req_rdy), 32'd1);
        cycle();
        chk("sparse_src0", 32'(out_src), 32'd0);

        // Reset mid-burst (ptr=2, cnt=1) discards the held beat and restarts at 0.
        drain();
        do_reset();
        cfg_weight = 16'h1311;
        req_vld    = 4'b1111;
        run_seq("pre_rst", 3, seq_c);
        rst     = 1'b1;
        out_rdy = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
        cycle();
        chk("mid_rst_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_src", 32'(out_src), 32'd0);
        chk_pd("mid_rst_pd", out_pd, '0);
        rx_seq[2] = rx_seq[2] + 16'd1;
        rst     = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        #1;
        chk("post_rst_rdy", 32'(req_rdy), 32'd1);
        cycle();
        chk("post_rst_src", 32'(out_src), 32'd0);

        // Random traffic with held valids and random back-pressure.
        for (int i = 0; i < NUM_REQ; i++) begin
            cfg_weight[i*WT_W +: WT_W] = 4'($urandom_range(1, 15));
        end
        for (int c = 0; c < 3000; c++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_vld[i] && !last_acc[i])) req_vld[i] = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        drain();
        for (int i = 0; i < NUM_REQ; i++) begin
            chk("no_loss", 32'(rx_seq[i]), 32'(tx_seq[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
